// File: rtl/serial_pkg.sv
// Shared definitions for the serial line blocks (recv_serial, send_serial):
// FSM state encoding, data width and bit-period computation.
package serial_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchronizer for asynchronous board inputs; the reset value is
// a parameter so idle-high and idle-low lines both come out of reset quietly.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/recv_serial.sv
// UART receiver, 8N1 by default; defining RECV_SERIAL_PARITY_EN switches to
// 8E1 framing and enables parity_err. Mid-bit sampling off a 2-FF synchronized line.
module recv_serial
    import serial_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic rx;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_in),
        .q   (rx)
    );

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] dout_n;
    logic              armed, armed_n;
    logic              valid_n, ferr_n;
`ifdef RECV_SERIAL_PARITY_EN
    logic              par_bit, par_bit_n;
    logic              perr_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            armed     <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef RECV_SERIAL_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            armed     <= armed_n;
            data_out  <= dout_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
`ifdef RECV_SERIAL_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= perr_n;
`endif
        end
    end

`ifndef RECV_SERIAL_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        armed_n = armed;
        dout_n  = data_out;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef RECV_SERIAL_PARITY_EN
        par_bit_n = par_bit;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A start edge is accepted only after the line was seen high,
                // so a held break cannot retrigger frames.
                cnt_n = '0;
                if (rx) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = START;
                    armed_n = 1'b0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx, shreg[DATA_W-1:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef RECV_SERIAL_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RECV_SERIAL_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bit_n = rx;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx) begin
                        ferr_n = 1'b1;
                    end
`ifdef RECV_SERIAL_PARITY_EN
                    else if (^{shreg, par_bit}) begin
                        perr_n = 1'b1;
                    end
`endif
                    else begin
                        valid_n = 1'b1;
                        dout_n  = shreg;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_recv_serial.sv
// Scoreboard bench for recv_serial at 100 MHz / 1 Mbaud (CPB=100, HALF=50):
// frames push expected events; a negedge monitor pops and compares them.
module tb_recv_serial;

    localparam int CPB  = 100;
    localparam int HALF = 50;
`ifdef RECV_SERIAL_PARITY_EN
    localparam int LAT = HALF + 10 * CPB + 3;
`else
    localparam int LAT = HALF + 9 * CPB + 3;
`endif

    localparam logic [2:0] EV_VALID = 3'b001;
    localparam logic [2:0] EV_FERR  = 3'b010;
    localparam logic [2:0] EV_PERR  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       data_in = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    ev_t        sb[$];
    logic [7:0] last_good = 8'h00;

    recv_serial #(
        .CLK_FREQ (100_000_000),
        .BAUD     (1_000_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_bit(input logic b);
        data_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Called at a negedge; the event is expected LAT cycles after the start edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
        ev_t  e;
        logic par;
        par = (^b) ^ pflip;
        e.cyc = cyc + LAT;
        if (!stop) begin
            e.kind = EV_FERR;
        end else begin
`ifdef RECV_SERIAL_PARITY_EN
            e.kind = pflip ? EV_PERR : EV_VALID;
`else
            e.kind = EV_VALID;
`endif
        end
        if (e.kind == EV_VALID) last_good = b;
        e.data = last_good;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RECV_SERIAL_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (valid || frame_err || parity_err) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=%b data_out=%02h required=none (cyc=%0d)",
                             {parity_err, frame_err, valid}, data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", int'({parity_err, frame_err, valid}), int'(e.kind));
                    chk("data_out", int'(data_out), int'(e.data));
                    chk("event_cycle", cyc, e.cyc);
                    chk("busy_at_pulse", int'(busy), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #(60_000 * 10);
        $display("FAIL watchdog actual=timeout required=finish (cyc=%0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int         c0;
        logic [7:0] b55;
        b55 = 8'h55;

        repeat (3) @(negedge clk);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Single frame, exact latency checked by the monitor.
        send_frame(8'h41, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);

        // Short low glitch: busy for the start-bit half period, no events.
        c0 = cyc;
        data_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_early", int'(busy), 1);
        repeat (10) @(negedge clk);
        data_in = 1'b1;
        repeat (c0 + HALF + 2 - cyc) @(negedge clk);
        chk("glitch_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("glitch_busy_clear", int'(busy), 0);
        repeat (CPB) @(negedge clk);

        // Stop bit forced low, then a long break: one frame_err only.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        data_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);

        // Reset in the middle of data bit 4 of a 0x55 frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b55[i]);
        data_in = b55[4];
        repeat (HALF) @(negedge clk);
        chk("busy_mid_frame", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_parity_err", int'(parity_err), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        data_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(8'h66, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);

`ifdef RECV_SERIAL_PARITY_EN
        send_frame(8'h41, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        send_frame(8'h41, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
`endif

        for (int i = 0; i < 20 * CPB && sb.size() > 0; i++) @(negedge clk);
        chk("pending_events", sb.size(), 0);
        repeat (2 * CPB) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
